// File: rtl/divider_pkg.sv
// divider_pkg: shared widths, iteration count and state encoding for the divider
package divider_pkg;
  localparam int RegWidth = 32;
  localparam int DoubleRegWidth = 64;
  localparam int IterCount = 32;
  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;
endpackage

// File: rtl/divider.sv
// divider: 32-step restoring divider, signed/unsigned, {remainder, quotient} result
module divider
  import divider_pkg::*;
(
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      start_i,
  input  logic                      signed_i,
  input  logic [RegWidth-1:0]       data1_i,
  input  logic [RegWidth-1:0]       data2_i,
  output logic [DoubleRegWidth-1:0] result_o,
  output logic                      done_o
);
  state_t state;
  logic [5:0] cnt;
  logic [DoubleRegWidth:0] acc, sh, nxt;
  logic [RegWidth-1:0] dvs, a_abs, b_abs, quo, rem;
  logic [RegWidth+1:0] diff;
  logic q_neg, r_neg;
  always_comb begin
    a_abs = (signed_i && data1_i[RegWidth-1]) ? -data1_i : data1_i;
    b_abs = (signed_i && data2_i[RegWidth-1]) ? -data2_i : data2_i;
    sh = acc << 1;
    diff = {1'b0, sh[DoubleRegWidth:RegWidth]} - {2'b0, dvs};
    // A borrow out of the 34-bit subtract means the divisor did not fit: restore
    nxt = diff[RegWidth+1] ? sh : {diff[RegWidth:0], sh[RegWidth-1:1], 1'b1};
    quo = q_neg ? -nxt[RegWidth-1:0] : nxt[RegWidth-1:0];
    rem = r_neg ? -nxt[DoubleRegWidth-1:RegWidth] : nxt[DoubleRegWidth-1:RegWidth];
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      cnt <= '0;
      acc <= '0;
      dvs <= '0;
      q_neg <= 1'b0;
      r_neg <= 1'b0;
      result_o <= '0;
      done_o <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          done_o <= 1'b0;
          if (start_i && data2_i == '0) begin
            result_o <= {data1_i, {RegWidth{1'b1}}};
            done_o <= 1'b1;
            state <= DONE;
          end else if (start_i) begin
            acc <= {{(RegWidth+1){1'b0}}, a_abs};
            dvs <= b_abs;
            q_neg <= signed_i & (data1_i[RegWidth-1] ^ data2_i[RegWidth-1]);
            r_neg <= signed_i & data1_i[RegWidth-1];
            cnt <= '0;
            state <= BUSY;
          end
        end
        BUSY: begin
          if (!start_i) begin
            state <= IDLE;
          end else begin
            acc <= nxt;
            cnt <= cnt + 6'd1;
            if (cnt == 6'(IterCount - 1)) begin
              result_o <= {rem, quo};
              done_o <= 1'b1;
              state <= DONE;
            end
          end
        end
        DONE: begin
          done_o <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_divider.sv
// tb_divider: directed vectors against an arithmetic model with a per-cycle scoreboard
module tb_divider;
  logic clk = 1'b0, rst = 1'b1, start_i = 1'b0, signed_i = 1'b0;
  logic [31:0] data1_i = '0, data2_i = '0;
  logic [63:0] result_o;
  logic done_o;

  divider dut (
    .clk(clk), .rst(rst), .start_i(start_i), .signed_i(signed_i),
    .data1_i(data1_i), .data2_i(data2_i), .result_o(result_o), .done_o(done_o)
  );

  always #5 clk = ~clk;

  typedef struct { int c; logic [63:0] v; } exp_t;
  exp_t q[$];
  int cyc = 0, n_chk = 0, n_fail = 0, k = 0, m = 0;
  logic rst_q = 1'b1;
  logic [63:0] held = '0;
  bit ed;

  always @(posedge clk) begin
    cyc <= cyc + 1;
    rst_q <= rst;
  end

  function automatic logic [63:0] model(logic [31:0] a, logic [31:0] b, logic s);
    longint sa, sb;
    logic [31:0] qq, rr;
    if (b == 0) return {a, 32'hFFFFFFFF};
    if (s) begin
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      qq = 32'(sa / sb);
      rr = 32'(sa % sb);
    end else begin
      qq = a / b;
      rr = a % b;
    end
    return {rr, qq};
  endfunction

  task automatic check(string name, logic [63:0] act, logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Scoreboard: done_o must pulse exactly on scheduled cycles; result_o holds between pulses
  always @(negedge clk) begin
    if (rst_q) begin
      held = '0;
      q.delete();
    end
    ed = q.size() > 0 && q[0].c == cyc;
    if (ed) begin
      held = q[0].v;
      void'(q.pop_front());
    end
    check("done_o", 64'(done_o), 64'(ed));
    check("result_o", result_o, held);
  end

  task automatic go(logic [31:0] a, logic [31:0] b, logic s, logic [63:0] exp);
    int lat;
    lat = (b == 0) ? 1 : 33;
    @(posedge clk); #1;
    data1_i = a; data2_i = b; signed_i = s; start_i = 1'b1;
    check("model", model(a, b, s), exp);
    q.push_back('{cyc + lat, exp});
    repeat (lat) @(posedge clk);
    #1 start_i = 1'b0;
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    go(32'd100, 32'd7, 1'b0, {32'h00000002, 32'h0000000E});
    go(32'hFFFFFFF9, 32'h2, 1'b1, {32'hFFFFFFFF, 32'hFFFFFFFD});
    go(32'h7, 32'hFFFFFFFE, 1'b1, {32'h00000001, 32'hFFFFFFFD});
    go(32'h80000000, 32'hFFFFFFFF, 1'b1, {32'h00000000, 32'h80000000});
    go(32'h80000000, 32'hFFFFFFFF, 1'b0, {32'h80000000, 32'h00000000});
    go(32'd5, 32'd0, 1'b0, {32'h00000005, 32'hFFFFFFFF});
    go(32'd5, 32'd0, 1'b1, {32'h00000005, 32'hFFFFFFFF});
    go(32'hFFFFFFFF, 32'd1, 1'b0, {32'h00000000, 32'hFFFFFFFF});
    go(32'hFFFFFF9C, 32'hFFFFFFF9, 1'b1, {32'hFFFFFFFE, 32'h0000000E});
    // abort after ten busy cycles, then a fresh division from idle
    @(posedge clk); #1;
    data1_i = 32'd1000; data2_i = 32'd3; signed_i = 1'b0; start_i = 1'b1;
    repeat (10) @(posedge clk);
    #1 start_i = 1'b0;
    go(32'h10, 32'h4, 1'b0, {32'h00000000, 32'h00000004});
    // back-to-back with start held; operands changed mid-BUSY feed only the second op
    @(posedge clk); #1;
    data1_i = 32'd1000; data2_i = 32'd10; signed_i = 1'b0; start_i = 1'b1;
    k = cyc;
    check("model b2b1", model(32'd1000, 32'd10, 1'b0), {32'h0, 32'd100});
    check("model b2b2", model(32'hFFFFFC18, 32'd7, 1'b1), {32'hFFFFFFFA, 32'hFFFFFF72});
    q.push_back('{k + 33, {32'h0, 32'd100}});
    q.push_back('{k + 67, {32'hFFFFFFFA, 32'hFFFFFF72}});
    repeat (20) @(posedge clk);
    #1 data1_i = 32'hFFFFFC18; data2_i = 32'd7; signed_i = 1'b1;
    repeat (47) @(posedge clk);
    #1 start_i = 1'b0;
    // reset in BUSY cycle 5 with start held; a fresh division follows the release
    @(posedge clk); #1;
    data1_i = 32'd500; data2_i = 32'd5; signed_i = 1'b0; start_i = 1'b1;
    q.push_back('{cyc + 33, {32'h0, 32'd100}});
    repeat (5) @(posedge clk);
    #1 rst = 1'b1; data1_i = 32'd81; data2_i = 32'd9;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    m = cyc;
    @(negedge clk); #1;
    check("model rst", model(32'd81, 32'd9, 1'b0), {32'h0, 32'd9});
    q.push_back('{m + 33, {32'h0, 32'd9}});
    repeat (33) @(posedge clk);
    #1 start_i = 1'b0;
    repeat (5) @(posedge clk);
    #1 check("pending", 64'(q.size()), 64'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/divider.md
DIVIDER -- requirements
Module: divider

Interface
REQ-001 clk  input  1  rising-edge clock for all state.
REQ-002 rst  input  1  reset; synchronous, active-high.
REQ-003 start_i  input  1  EX requests a division; held high until done_o is seen; low means no request or abort.
REQ-004 signed_i  input  1  1 = DIV.W/MOD.W semantics, 0 = DIV.WU/MOD.WU; sampled with operands.
REQ-005 data1_i  input  32  dividend.
REQ-006 data2_i  input  32  divisor.
REQ-007 result_o  output  64  {remainder[63:32], quotient[31:0]}; registered.
REQ-008 done_o  output  1  result_o valid; registered, one-cycle pulse.

Function
REQ-009 States SHALL be IDLE, BUSY, DONE; the encoding is a shared constant.
REQ-010 IDLE, start_i=1, data2_i!=0: the block SHALL latch |data1_i| and |data2_i| (absolute values only when signed_i=1), the quotient sign (data1^data2 sign bits) and the remainder sign (data1 sign), clear a 6-bit counter, and go to BUSY.
REQ-011 IDLE, start_i=1, data2_i==0: the block SHALL go directly to DONE with quotient 0xFFFFFFFF and remainder data1_i, regardless of signed_i.
REQ-012 BUSY: the block SHALL perform one restoring shift-subtract step per cycle on a 65-bit partial-remainder/quotient register, for 32 steps, then go to DONE.
REQ-013 On entry to DONE, result_o SHALL hold the sign-corrected quotient (negated if quotient sign=1) and remainder (negated if remainder sign=1); quotient truncates toward zero.
REQ-014 Latency: done_o SHALL be high exactly 33 cycles after the first cycle start_i is sampled high in IDLE (divisor non-zero), and 1 cycle after for divisor zero.
REQ-015 DONE: done_o=1 for exactly one cycle; the next state SHALL be IDLE unconditionally, even if start_i is high.
REQ-016 A start_i still high in the IDLE cycle after DONE SHALL begin a new division (back-to-back DIV in EX).
REQ-017 BUSY with start_i=0 (pipeline flush) SHALL abort to IDLE on the next edge; done_o stays 0 and result_o is unchanged.
REQ-018 Changes on data1_i/data2_i/signed_i during BUSY SHALL be ignored.
REQ-019 Signed 0x80000000 / 0xFFFFFFFF SHALL yield quotient 0x80000000 and remainder 0 with no special case beyond REQ-010..013.
REQ-020 result_o SHALL hold its last value until the next entry to DONE.

Reset
REQ-021 rst=1 SHALL force state IDLE, counter 0, result_o 0, done_o 0, and all internal operand registers 0.
REQ-022 rst asserted during BUSY or DONE SHALL take effect at the next edge; no done_o pulse follows.
REQ-023 After rst deasserts, a held start_i SHALL begin a fresh division per REQ-010.

Structure
REQ-024 The state encoding, the 32/64-bit width macros (RegWidth, DoubleRegWidth) and the iteration count constant (32) SHALL live in the shared define file.
REQ-025 The block SHALL be a single module with no sub-module; negation and the subtract step are inline logic.

Verification
REQ-026 Unsigned 100/7, start held -> done_o at cycle 33, result_o = {0x00000002, 0x0000000E}.
REQ-027 Signed -7/2 (0xFFFFFFF9/0x00000002) -> result_o = {0xFFFFFFFF, 0xFFFFFFFD}; signed 7/-2 -> {0x00000001, 0xFFFFFFFD}.
REQ-028 0x80000000/0xFFFFFFFF -> signed {0x00000000, 0x80000000}; unsigned {0x80000000, 0x00000000}.
REQ-029 5/0, either signedness -> done_o one cycle after start, result_o = {0x00000005, 0xFFFFFFFF}.
REQ-030 Abort: start_i dropped at BUSY cycle 10 -> no done_o, IDLE next cycle, result_o unchanged; then start 0x10/4 -> {0, 0x4} after 33 cycles.
REQ-031 Two back-to-back divisions with start_i held high across DONE -> exactly two single-cycle done_o pulses 34 cycles apart; rst at BUSY cycle 5 -> IDLE, all outputs 0, no pulse.
